// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/step/breakpoint controller that sequences the processor datapath.
// It debounces the run/step/halt buttons and gates the per-instruction clock
// enable. It also holds the datapath in reset until the first CPU tick.
// Execution stops on a PC breakpoint, a halt instruction or a halt press.
//
// Ports
//   clk_pi          system clock
//   reset_pi        asynchronous active-low reset
//   tick_en_pi      one-cycle CPU-rate enable from the clock divider
//   run_btn_pi      raw run button (active-high, asynchronous)
//   step_btn_pi     raw step button (active-high, asynchronous)
//   halt_btn_pi     raw halt button (active-high, asynchronous)
//   pc_pi           current program counter
//   halt_cmd_pi     decoded halt instruction at pc_pi
//   rst_cmd_pi      decoded software-reset instruction at pc_pi
//   bp_enable_pi    breakpoint enable
//   bp_addr_pi      breakpoint address
//   cpu_clk_en_po   datapath clock enable (combinational)
//   cpu_reset_po    active-high datapath reset (registered)
//   state_po        INIT=0, HALTED=1, RUN=2, STEP=3, BREAK=4
//   break_hit_po    high while in BREAK (registered)
//   cycle_count_po  executed-instruction count, saturating (registered)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PC_WIDTH        = 16
) (
    input  logic                clk_pi,
    input  logic                reset_pi,
    input  logic                tick_en_pi,
    input  logic                run_btn_pi,
    input  logic                step_btn_pi,
    input  logic                halt_btn_pi,
    input  logic [PC_WIDTH-1:0] pc_pi,
    input  logic                halt_cmd_pi,
    input  logic                rst_cmd_pi,
    input  logic                bp_enable_pi,
    input  logic [PC_WIDTH-1:0] bp_addr_pi,
    output logic                cpu_clk_en_po,
    output logic                cpu_reset_po,
    output logic [2:0]          state_po,
    output logic                break_hit_po,
    output logic [15:0]         cycle_count_po
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_HALTED = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_e;

    // Debounce counter value on which the level is allowed to flip.
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Button bit order everywhere: [0]=run, [1]=step, [2]=halt.
    logic [2:0]       btn_raw_s;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       level_q, level_d, level_prev_q;
    logic [2:0][15:0] db_cnt_q, db_cnt_d;
    logic [2:0]       press_s;
    logic             run_press_s, step_press_s, halt_press_s;

    state_e           state_q, state_d;
    logic             skip_bp_q, skip_bp_d;
    logic [15:0]      count_q, count_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             break_hit_q, break_hit_d;
    logic             clk_en_s;
    logic             bp_stop_s;

    assign btn_raw_s = {halt_btn_pi, step_btn_pi, run_btn_pi};

    // Debounce next-state: the level flips only after the synchronized value
    // has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = sync2_q[i];
                    db_cnt_d[i] = 16'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end else begin
                db_cnt_d[i] = 16'd0;
            end
        end
    end

    // Synchronizer, debounce and edge-detect registers for all three buttons.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            level_q      <= 3'b000;
            level_prev_q <= 3'b000;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= btn_raw_s;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // One-cycle press pulse on each rising edge of the debounced level.
    assign press_s      = level_q & ~level_prev_q;
    assign run_press_s  = press_s[0];
    assign step_press_s = press_s[1];
    assign halt_press_s = press_s[2];

    // skip_bp lets a run press resume from the breakpoint address itself.
    assign bp_stop_s = bp_enable_pi & ~skip_bp_q & (pc_pi == bp_addr_pi);

    // Run-control FSM next state and the combinational datapath enable.
    always_comb begin
        state_d   = state_q;
        skip_bp_d = skip_bp_q;
        clk_en_s  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (tick_en_pi) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_INIT;
                end
            end
            // A halt press has no effect while stopped; step outranks run.
            ST_HALTED, ST_BREAK: begin
                if (step_press_s) begin
                    state_d = ST_STEP;
                end else if (run_press_s) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            // A stop on this tick outranks any press arriving with it.
            ST_RUN: begin
                clk_en_s = tick_en_pi & ~halt_cmd_pi & ~bp_stop_s;
                if (tick_en_pi && halt_cmd_pi) begin
                    state_d = ST_HALTED;
                end else if (tick_en_pi && bp_stop_s) begin
                    state_d = ST_BREAK;
                end else if (halt_press_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
                if (clk_en_s) begin
                    skip_bp_d = 1'b0;
                end else begin
                    skip_bp_d = skip_bp_q;
                end
            end
            // Breakpoints are deliberately not consulted in STEP.
            ST_STEP: begin
                clk_en_s = tick_en_pi & ~halt_cmd_pi & ~halt_press_s;
                if (halt_press_s || tick_en_pi) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d   = ST_INIT;
                skip_bp_d = 1'b0;
            end
        endcase
    end

    // Instruction counter: cleared in INIT and by a software-reset instruction.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_INIT) begin
            count_d = 16'd0;
        end else if (clk_en_s) begin
            if (rst_cmd_pi) begin
                count_d = 16'd0;
            end else if (count_q == 16'hFFFF) begin
                count_d = 16'hFFFF;
            end else begin
                count_d = count_q + 16'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        cpu_reset_d = (state_d == ST_INIT);
        break_hit_d = (state_d == ST_BREAK);
    end

    // FSM state, skip flag, counter and status output registers.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            state_q     <= ST_INIT;
            skip_bp_q   <= 1'b0;
            count_q     <= 16'd0;
            cpu_reset_q <= 1'b1;
            break_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_bp_q   <= skip_bp_d;
            count_q     <= count_d;
            cpu_reset_q <= cpu_reset_d;
            break_hit_q <= break_hit_d;
        end
    end

    assign cpu_clk_en_po  = clk_en_s;
    assign cpu_reset_po   = cpu_reset_q;
    assign state_po       = state_q;
    assign break_hit_po   = break_hit_q;
    assign cycle_count_po = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4 and a CPU tick
// every 8 clocks. A behavioural model (run-control rules plus a tiny datapath
// that advances pc on each executed instruction) predicts every cycle.
// Button presses are predicted from the stated latency of a clean press.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam logic [2:0] M_INIT   = 3'd0;
    localparam logic [2:0] M_HALTED = 3'd1;
    localparam logic [2:0] M_RUN    = 3'd2;
    localparam logic [2:0] M_STEP   = 3'd3;
    localparam logic [2:0] M_BREAK  = 3'd4;
    // Edges from the first sampled-high edge to the edge consuming the press:
    // 2 sync + 4 debounce + 1 pulse cycle.
    localparam int PRESS_LAT = 7;

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic        tick_en_pi;
    logic        run_btn_pi, step_btn_pi, halt_btn_pi;
    logic [15:0] pc_pi;
    logic        halt_cmd_pi, rst_cmd_pi;
    logic        bp_enable_pi;
    logic [15:0] bp_addr_pi;
    logic        cpu_clk_en_po, cpu_reset_po, break_hit_po;
    logic [2:0]  state_po;
    logic [15:0] cycle_count_po;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .PC_WIDTH(16)) dut (
        .clk_pi        (clk_pi),
        .reset_pi      (reset_pi),
        .tick_en_pi    (tick_en_pi),
        .run_btn_pi    (run_btn_pi),
        .step_btn_pi   (step_btn_pi),
        .halt_btn_pi   (halt_btn_pi),
        .pc_pi         (pc_pi),
        .halt_cmd_pi   (halt_cmd_pi),
        .rst_cmd_pi    (rst_cmd_pi),
        .bp_enable_pi  (bp_enable_pi),
        .bp_addr_pi    (bp_addr_pi),
        .cpu_clk_en_po (cpu_clk_en_po),
        .cpu_reset_po  (cpu_reset_po),
        .state_po      (state_po),
        .break_hit_po  (break_hit_po),
        .cycle_count_po(cycle_count_po)
    );

    always #5 clk_pi = ~clk_pi;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    logic [2:0]  m_state;
    bit          m_skip;
    int          m_cnt;
    logic [15:0] pc_r;
    logic [15:0] halt_pc = 16'hFFFF;
    logic [15:0] rst_pc  = 16'hFFFF;
    int          ecnt = 0;
    int          hold [3] = '{0, 0, 0};
    int          sched_run[$], sched_step[$], sched_halt[$];
    bit          obs_en, exp_en, saw_rst_exec;
    int          en_pulses_obs = 0;
    int          en_mis = 0, vec_mis = 0;
    logic [20:0] last_obs, last_exp;

    // True (and removes it) if a press of button b is due on the coming edge.
    function automatic bit take(input int b);
        int e;
        e = ecnt + 1;
        case (b)
            0: if (sched_run.size() > 0 && sched_run[0] == e) begin
                   void'(sched_run.pop_front()); return 1'b1; end
            1: if (sched_step.size() > 0 && sched_step[0] == e) begin
                   void'(sched_step.pop_front()); return 1'b1; end
            default: if (sched_halt.size() > 0 && sched_halt[0] == e) begin
                   void'(sched_halt.pop_front()); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Clean press: hold 6 cycles, press consumed PRESS_LAT edges later.
    task automatic press(input int b);
        hold[b] = 6;
        case (b)
            0: sched_run.push_back(ecnt + PRESS_LAT);
            1: sched_step.push_back(ecnt + PRESS_LAT);
            default: sched_halt.push_back(ecnt + PRESS_LAT);
        endcase
    endtask

    task automatic bounce(input int b);
        hold[b] = 1;
    endtask

    // One clock cycle: drive inputs, predict, sample enable mid-cycle, step model.
    task automatic cyc();
        bit tick, hcmd, rcmd, pr, ps, ph, bp_stop, en, nskip;
        logic [2:0] nxt;
        tick = ((ecnt + 1) % 8 == 0);
        hcmd = (pc_r == halt_pc);
        rcmd = (pc_r == rst_pc);
        tick_en_pi  = tick;
        pc_pi       = pc_r;
        halt_cmd_pi = hcmd;
        rst_cmd_pi  = rcmd;
        run_btn_pi  = (hold[0] > 0);
        step_btn_pi = (hold[1] > 0);
        halt_btn_pi = (hold[2] > 0);
        pr = take(0);
        ps = take(1);
        ph = take(2);
        bp_stop = bp_enable_pi && !m_skip && (pc_r == bp_addr_pi);
        en = 1'b0;
        nxt = m_state;
        nskip = m_skip;
        case (m_state)
            M_INIT: if (tick) nxt = M_HALTED;
            M_HALTED, M_BREAK: begin
                if (ps) nxt = M_STEP;
                else if (pr) begin nxt = M_RUN; nskip = 1'b1; end
            end
            M_RUN: begin
                en = tick && !hcmd && !bp_stop;
                if (tick && hcmd) nxt = M_HALTED;
                else if (tick && bp_stop) nxt = M_BREAK;
                else if (ph) nxt = M_HALTED;
                if (en) nskip = 1'b0;
            end
            M_STEP: begin
                en = tick && !hcmd && !ph;
                if (ph || tick) nxt = M_HALTED;
            end
            default: nxt = M_INIT;
        endcase
        exp_en = en;
        #3;
        obs_en = cpu_clk_en_po;
        if (obs_en !== exp_en) en_mis++;
        if (obs_en) en_pulses_obs++;
        @(posedge clk_pi);
        ecnt++;
        if (m_state == M_INIT) begin
            m_cnt = 0;
            pc_r  = 16'd0;
        end else if (en) begin
            if (rcmd) begin
                m_cnt = 0;
                pc_r  = 16'd0;
                saw_rst_exec = 1'b1;
            end else begin
                if (m_cnt < 65535) m_cnt++;
                pc_r = pc_r + 16'd1;
            end
        end
        m_state = nxt;
        m_skip  = nskip;
        for (int i = 0; i < 3; i++) if (hold[i] > 0) hold[i]--;
        #1;
        last_obs = {state_po, cpu_reset_po, break_hit_po, cycle_count_po};
        last_exp = {m_state, (m_state == M_INIT), (m_state == M_BREAK), 16'(m_cnt)};
        if (last_obs !== last_exp) vec_mis++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic run_until(input logic [2:0] st, input int bound, output bit ok);
        int k;
        k = 0;
        while (m_state != st && k < bound) begin cyc(); k++; end
        ok = (m_state == st);
    endtask

    // Assert async reset mid-cycle; caller may check outputs right after.
    task automatic assert_reset();
        reset_pi    = 1'b0;
        tick_en_pi  = 1'b0;
        run_btn_pi  = 1'b0;
        step_btn_pi = 1'b0;
        halt_btn_pi = 1'b0;
        for (int i = 0; i < 3; i++) hold[i] = 0;
        sched_run.delete();
        sched_step.delete();
        sched_halt.delete();
        m_state = M_INIT;
        m_skip  = 1'b0;
        m_cnt   = 0;
        pc_r    = 16'd0;
        #2;
    endtask

    task automatic release_reset();
        repeat (2) begin @(posedge clk_pi); ecnt++; end
        #1;
        reset_pi = 1'b1;
    endtask

    task automatic check_trace(input string name);
        n_tests++;
        if (vec_mis !== 0 || en_mis !== 0) begin
            n_fail++;
            $display("FAIL %s_trace: en_mis=%0d vec_mis=%0d last {state,rst,brk,cnt} got=%h want=%h",
                     name, en_mis, vec_mis, last_obs, last_exp);
        end
        vec_mis = 0;
        en_mis  = 0;
    endtask

    task automatic test_reset();
        bit ok;
        assert_reset();
        n_tests++;
        if ({state_po, cpu_reset_po, break_hit_po, cycle_count_po, cpu_clk_en_po} !==
            {M_INIT, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got st=%0d rst=%b brk=%b cnt=%0d en=%b want 0/1/0/0/0",
                     state_po, cpu_reset_po, break_hit_po, cycle_count_po, cpu_clk_en_po);
        end
        release_reset();
        vec_mis = 0; en_mis = 0;
        run_until(M_HALTED, 20, ok);
        n_tests++;
        if (!ok || state_po !== M_HALTED || cpu_reset_po !== 1'b0 || cycle_count_po !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_first_tick: got st=%0d rst=%b cnt=%0d want st=1 rst=0 cnt=0",
                     state_po, cpu_reset_po, cycle_count_po);
        end
        check_trace("reset");
    endtask

    task automatic test_step();
        bit ok1, ok2;
        bounce(1);
        idle(20);
        n_tests++;
        if (state_po !== M_HALTED) begin
            n_fail++;
            $display("FAIL step_bounce: got state %0d want 1", state_po);
        end
        en_pulses_obs = 0;
        press(1);
        run_until(M_STEP, 20, ok1);
        run_until(M_HALTED, 20, ok2);
        idle(10);
        n_tests++;
        if (!ok1 || !ok2 || en_pulses_obs !== 1 || cycle_count_po !== 16'd1 || state_po !== M_HALTED) begin
            n_fail++;
            $display("FAIL step_single: pulses=%0d cnt=%0d st=%0d want 1/1/1",
                     en_pulses_obs, cycle_count_po, state_po);
        end
        check_trace("step");
    endtask

    task automatic test_breakpoint();
        bit ok;
        assert_reset();
        release_reset();
        run_until(M_HALTED, 20, ok);
        bp_enable_pi = 1'b1;
        bp_addr_pi   = 16'h0005;
        en_pulses_obs = 0;
        press(0);
        run_until(M_BREAK, 200, ok);
        n_tests++;
        if (!ok || state_po !== M_BREAK || break_hit_po !== 1'b1 || cycle_count_po !== 16'd5 ||
            en_pulses_obs !== 5) begin
            n_fail++;
            $display("FAIL bp_stop: st=%0d brk=%b cnt=%0d pulses=%0d want 4/1/5/5",
                     state_po, break_hit_po, cycle_count_po, en_pulses_obs);
        end
        idle(24);
        n_tests++;
        if (en_pulses_obs !== 5 || state_po !== M_BREAK) begin
            n_fail++;
            $display("FAIL bp_hold: pulses=%0d st=%0d want 5/4", en_pulses_obs, state_po);
        end
        press(0);
        idle(60);
        n_tests++;
        if (state_po !== M_RUN || cycle_count_po < 16'd8 || break_hit_po !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_resume: st=%0d cnt=%0d brk=%b want 2/>=8/0",
                     state_po, cycle_count_po, break_hit_po);
        end
        press(2);
        run_until(M_HALTED, 20, ok);
        bp_enable_pi = 1'b0;
        idle(20);
        check_trace("bp");
    endtask

    task automatic test_halt_cmd();
        bit ok1, ok2;
        int cnt0, p0;
        halt_pc = pc_r + 16'd3;
        cnt0 = m_cnt;
        press(0);
        run_until(M_RUN, 20, ok1);
        run_until(M_HALTED, 100, ok2);
        p0 = en_pulses_obs;
        idle(24);
        n_tests++;
        if (!ok1 || !ok2 || state_po !== M_HALTED || cycle_count_po !== 16'(cnt0 + 3) ||
            en_pulses_obs !== p0) begin
            n_fail++;
            $display("FAIL halt_cmd: st=%0d cnt=%0d want st=1 cnt=%0d, extra pulses=%0d",
                     state_po, cycle_count_po, cnt0 + 3, en_pulses_obs - p0);
        end
        halt_pc = 16'hFFFF;
        check_trace("halt_cmd");
    endtask

    task automatic test_halt_run_same();
        bit ok;
        press(0);
        run_until(M_RUN, 20, ok);
        idle(20);
        press(0);
        press(2);
        idle(12);
        n_tests++;
        if (!ok || state_po !== M_HALTED) begin
            n_fail++;
            $display("FAIL halt_run_same: got st=%0d want 1", state_po);
        end
        idle(10);
        check_trace("halt_run");
    endtask

    task automatic test_rst_cmd();
        bit ok;
        int k;
        assert_reset();
        release_reset();
        run_until(M_HALTED, 20, ok);
        rst_pc = 16'd37;
        saw_rst_exec = 1'b0;
        press(0);
        k = 0;
        while (!(m_state == M_RUN && pc_r == 16'd37) && k < 500) begin cyc(); k++; end
        n_tests++;
        if (cycle_count_po !== 16'd37) begin
            n_fail++;
            $display("FAIL rst_cmd_pre: got cnt=%0d want 37", cycle_count_po);
        end
        k = 0;
        while (!saw_rst_exec && k < 20) begin cyc(); k++; end
        n_tests++;
        if (!saw_rst_exec || cycle_count_po !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_cmd_clear: got cnt=%0d want 0", cycle_count_po);
        end
        rst_pc = 16'hFFFF;
        press(2);
        run_until(M_HALTED, 20, ok);
        idle(20);
        check_trace("rst_cmd");
    endtask

    task automatic test_reset_in_step();
        bit ok;
        int p0;
        while (ecnt % 8 != 4) cyc();
        p0 = en_pulses_obs;
        press(1);
        run_until(M_STEP, 10, ok);
        assert_reset();
        n_tests++;
        if (!ok || state_po !== M_INIT || cpu_reset_po !== 1'b1 || cpu_clk_en_po !== 1'b0 ||
            cycle_count_po !== 16'd0 || en_pulses_obs !== p0) begin
            n_fail++;
            $display("FAIL reset_in_step: st=%0d rst=%b en=%b cnt=%0d pulses+%0d want 0/1/0/0/+0",
                     state_po, cpu_reset_po, cpu_clk_en_po, cycle_count_po, en_pulses_obs - p0);
        end
        release_reset();
        vec_mis = 0; en_mis = 0;
        run_until(M_HALTED, 20, ok);
        idle(20);
        n_tests++;
        if (!ok || state_po !== M_HALTED || en_pulses_obs !== p0) begin
            n_fail++;
            $display("FAIL reset_in_step_after: st=%0d pulses+%0d want 1/+0",
                     state_po, en_pulses_obs - p0);
        end
        check_trace("reset_step");
    endtask

    task automatic test_random();
        bit ok;
        int b;
        for (int it = 0; it < 6; it++) begin
            assert_reset();
            release_reset();
            run_until(M_HALTED, 20, ok);
            bp_enable_pi = 1'($urandom_range(0, 1));
            bp_addr_pi   = 16'($urandom_range(1, 12));
            halt_pc      = 16'($urandom_range(8, 30));
            rst_pc       = 16'($urandom_range(0, 40));
            for (int j = 0; j < 8; j++) begin
                b = $urandom_range(0, 2);
                if ($urandom_range(0, 5) == 0) bounce(b);
                else press(b);
                idle($urandom_range(20, 60));
            end
            n_tests++;
            if (cycle_count_po !== 16'(m_cnt) || state_po !== m_state) begin
                n_fail++;
                $display("FAIL random_end_%0d: cnt=%0d st=%0d want cnt=%0d st=%0d",
                         it, cycle_count_po, state_po, m_cnt, m_state);
            end
            check_trace("random");
        end
        bp_enable_pi = 1'b0;
        halt_pc = 16'hFFFF;
        rst_pc  = 16'hFFFF;
    endtask

    initial begin
        reset_pi     = 1'b0;
        tick_en_pi   = 1'b0;
        run_btn_pi   = 1'b0;
        step_btn_pi  = 1'b0;
        halt_btn_pi  = 1'b0;
        pc_pi        = 16'd0;
        halt_cmd_pi  = 1'b0;
        rst_cmd_pi   = 1'b0;
        bp_enable_pi = 1'b0;
        bp_addr_pi   = 16'd0;
        m_state      = M_INIT;
        m_skip       = 1'b0;
        m_cnt        = 0;
        pc_r         = 16'd0;
        @(posedge clk_pi);
        ecnt++;
        #1;
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_cmd();
        test_halt_run_same();
        test_rst_cmd();
        test_reset_in_step();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller that sequences the processor datapath. It sits between the CPU clock-enable divider and the datapath (regfile, program counter, data memory). It gates the per-instruction enable and issues the datapath power-on reset pulse. It also debounces the run/step/halt buttons and stops execution on a PC breakpoint, a halt instruction or a halt button press.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable clk_pi cycles required before a debounced button level changes (1..65535).
- PC_WIDTH, 16: width of pc_pi and bp_addr_pi.

- clk_pi  in  1  system clock; the only clock.
- reset_pi  in  1  asynchronous, active-low reset.
- tick_en_pi  in  1  one-cycle CPU-rate enable from the clock divider.
- run_btn_pi, step_btn_pi, halt_btn_pi  in  1 each  raw asynchronous buttons, active-high.
- pc_pi  in  PC_WIDTH  current program counter.
- halt_cmd_pi  in  1  decoded halt instruction at pc_pi.
- rst_cmd_pi  in  1  decoded software-reset instruction at pc_pi.
- bp_enable_pi  in  1  breakpoint enable.
- bp_addr_pi  in  PC_WIDTH  breakpoint address.
- cpu_clk_en_po  out  1  datapath clock enable (combinational).
- cpu_reset_po  out  1  active-high datapath reset (registered).
- state_po  out  3  FSM state: INIT=0, HALTED=1, RUN=2, STEP=3, BREAK=4.
- break_hit_po  out  1  high while in BREAK (registered).
- cycle_count_po  out  16  executed-instruction count (registered).

## Operation
- Button path, per button:
  - 2-flop synchronizer.
  - Debounced level updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive clk_pi cycles.
  - A rising edge of the debounced level gives a one-cycle press pulse.
  - Synchronizers and levels reset to 0, so a button held through reset produces one press after it debounces.
- Press priority when pulses coincide: halt > step > run. Presses with no transition in the current state are dropped, not queued.
- "Exec tick" means a clk_pi cycle in which cpu_clk_en_po=1.
- INIT:
  - cpu_reset_po=1, cpu_clk_en_po=0.
  - Leaves on the first tick_en_pi=1 cycle, which the datapath sees as its reset cycle. Goes to HALTED.
- HALTED: enable 0.
  - Step press goes to STEP.
  - Run press goes to RUN and sets skip_bp.
- RUN: cpu_clk_en_po = tick_en_pi & ~halt_cmd_pi & ~bp_stop, where bp_stop = bp_enable_pi & ~skip_bp & (pc_pi==bp_addr_pi).
  - A tick with halt_cmd_pi goes to HALTED.
  - A tick with bp_stop goes to BREAK; the instruction at bp_addr_pi is not executed.
  - A halt press goes to HALTED immediately; it does not wait for a tick.
  - skip_bp clears on the first exec tick.
- STEP: waits for tick_en_pi.
  - On that tick, if halt_cmd_pi=1: no exec, go to HALTED.
  - Otherwise: exactly one exec tick, then HALTED.
  - Breakpoints are ignored in STEP.
  - A halt press in STEP aborts to HALTED without exec.
- BREAK: break_hit_po=1, enable 0. Run press goes to RUN and sets skip_bp. Step press goes to STEP.
- cycle_count_po:
  - Increments on every exec tick and saturates at 16'hFFFF.
  - Clears in INIT.
  - An exec tick with rst_cmd_pi=1 loads 0 instead of incrementing; the datapath performs its own reset.

## Timing
- Async reset, any cycle: state=INIT, cpu_reset_po=1, cpu_clk_en_po=0, break_hit_po=0, cycle_count_po=0, skip_bp=0.
  - Mid-instruction reset abandons the current state and any pending press.
- Button latency: press pulse occurs 2 (sync) + DEBOUNCE_CYCLES + 1 clk_pi cycles after a clean rising edge.
- The press pulse is consumed in the same cycle. The state change is visible on state_po the next cycle.
- cpu_clk_en_po:
  - Zero-latency combinational function of registered state, tick_en_pi and the decode/PC inputs.
  - Never high when tick_en_pi=0.
  - Never high in INIT, HALTED or BREAK.
- Exec tick to counter: cycle_count_po updates on the clk_pi edge ending the exec tick.
- A press arriving in the same cycle as a RUN tick with halt/breakpoint stop: the stop transition wins and the press is dropped.
- pc_pi, halt_cmd_pi and rst_cmd_pi must be stable whenever tick_en_pi=1.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and tick_en_pi every 8 clk_pi.
- Reset, then the first tick -> cpu_reset_po=1 exactly until that tick; state_po 0 then 1; cycle_count_po=0.
- Step press with pc advancing and no halt -> exactly one cpu_clk_en_po pulse, cycle_count_po=1, state_po returns to 1. A 1-cycle bounce on step_btn_pi produces no press.
- bp_enable_pi=1, bp_addr_pi=16'h0005, run from pc 0:
  - Exec ticks occur for pc 0..4 and no enable at pc 5; state_po=4, break_hit_po=1, cycle_count_po=5.
  - A second run press executes pc 5 and continues.
- RUN reaches halt_cmd_pi=1 -> no enable on that tick; state_po=1, count frozen.
- Halt and run pressed in the same cycle during RUN -> HALTED.
- Exec tick with rst_cmd_pi=1 at count 37 -> cycle_count_po=0. Async reset in STEP before the tick -> INIT with no exec.
